// File: rtl/ws2812b_pkg.sv
// Shared constants and types for the WS2812B line driver.
// Timing values assume a 20 MHz clock.
`timescale 1ns/1ps
package ws2812b_pkg;

    localparam int WORD_W     = 24;
    localparam int T0H_DEF    = 8;
    localparam int T1H_DEF    = 16;
    localparam int TBIT_DEF   = 25;
    localparam int TLATCH_DEF = 1200;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_HIGH  = 2'd1;
    localparam logic [1:0] S_LOW   = 2'd2;
    localparam logic [1:0] S_LATCH = 2'd3;

    typedef struct packed {
        logic [WORD_W-1:0] data;
        logic              lat;
    } pixel_t;

endpackage

// File: rtl/ws2812b_bit_timer.sv
// Cycle counter for one bit slot or the latch gap.
// Flags are one cycle ahead so the registered led lines up.
`timescale 1ns/1ps
module ws2812b_bit_timer
    import ws2812b_pkg::*;
#(
    parameter int T0H    = T0H_DEF,
    parameter int T1H    = T1H_DEF,
    parameter int TBIT   = TBIT_DEF,
    parameter int TLATCH = TLATCH_DEF,
    parameter int CW     = $clog2(TLATCH)
) (
    input  logic clk20,
    input  logic reset,
    input  logic clr,
    input  logic bit_val,
    output logic hi_done,
    output logic bit_done,
    output logic latch_done
);

    localparam logic [CW-1:0] HI0_END = CW'(T0H - 1);
    localparam logic [CW-1:0] HI1_END = CW'(T1H - 1);
    localparam logic [CW-1:0] BIT_END = CW'(TBIT - 1);
    localparam logic [CW-1:0] LAT_END = CW'(TLATCH - 1);

    logic [CW-1:0] cyc;

    always_ff @(posedge clk20 or posedge reset) begin
        if (reset) begin
            cyc <= '0;
        end else if (clr) begin
            cyc <= '0;
        end else begin
            cyc <= cyc + CW'(1);
        end
    end

    assign hi_done    = cyc >= (bit_val ? HI1_END : HI0_END);
    assign bit_done   = cyc == BIT_END;
    assign latch_done = cyc == LAT_END;

endmodule

// File: rtl/ws2812b_serializer.sv
// WS2812B single-wire serializer with a one-word holding register.
// Words chain without gaps while the hold is refilled in time.
`timescale 1ns/1ps
module ws2812b_serializer
    import ws2812b_pkg::*;
#(
    parameter int T0H    = T0H_DEF,
    parameter int T1H    = T1H_DEF,
    parameter int TBIT   = TBIT_DEF,
    parameter int TLATCH = TLATCH_DEF
) (
    input  logic              clk20,
    input  logic              reset,
    input  logic [WORD_W-1:0] data_in,
    input  logic              valid,
    input  logic              latch,
    output logic              ready,
    output logic              led
);

    logic [1:0]        state;
    logic [1:0]        state_n;
    pixel_t            hold;
    logic              hold_full;
    logic              hold_full_n;
    logic [WORD_W-1:0] shreg;
    logic [4:0]        bit_idx;
    logic              cur_lat;
    logic              acc;
    logic              load;
    logic              shift;
    logic              cyc_clr;
    logic              hi_done;
    logic              bit_done;
    logic              latch_done;

    assign acc         = valid && ready;
    assign hold_full_n = (hold_full && !load) || acc;

    ws2812b_bit_timer #(
        .T0H    (T0H),
        .T1H    (T1H),
        .TBIT   (TBIT),
        .TLATCH (TLATCH)
    ) u_timer (
        .clk20      (clk20),
        .reset      (reset),
        .clr        (cyc_clr),
        .bit_val    (shreg[WORD_W-1]),
        .hi_done    (hi_done),
        .bit_done   (bit_done),
        .latch_done (latch_done)
    );

    always_comb begin
        state_n = state;
        load    = 1'b0;
        shift   = 1'b0;
        cyc_clr = 1'b0;
        unique case (1'b1)
            (state == S_IDLE): begin
                cyc_clr = 1'b1;
                if (hold_full) begin
                    load    = 1'b1;
                    state_n = S_HIGH;
                end
            end
            (state == S_HIGH): begin
                if (hi_done) state_n = S_LOW;
            end
            (state == S_LOW): begin
                if (bit_done) begin
                    cyc_clr = 1'b1;
                    if (bit_idx != 5'd0) begin
                        shift   = 1'b1;
                        state_n = S_HIGH;
                    end else if (cur_lat) begin
                        state_n = S_LATCH;
                    end else if (hold_full) begin
                        // chain straight into the next word
                        load    = 1'b1;
                        state_n = S_HIGH;
                    end else begin
                        state_n = S_IDLE;
                    end
                end
            end
            (state == S_LATCH): begin
                if (latch_done) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk20 or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            hold      <= '0;
            hold_full <= 1'b0;
            ready     <= 1'b0;
            led       <= 1'b0;
            shreg     <= '0;
            bit_idx   <= '0;
            cur_lat   <= 1'b0;
        end else begin
            state     <= state_n;
            hold_full <= hold_full_n;
            ready     <= !hold_full_n;
            led       <= (state_n == S_HIGH);
            if (acc) begin
                hold <= '{data: data_in, lat: latch};
            end
            if (load) begin
                shreg   <= hold.data;
                cur_lat <= hold.lat;
                bit_idx <= 5'(WORD_W - 1);
            end else if (shift) begin
                shreg   <= {shreg[WORD_W-2:0], 1'b0};
                bit_idx <= bit_idx - 5'd1;
            end
        end
    end

endmodule
